// File: rtl/tick_period_meter.sv
// Measures the clock interval between tick_in events and reports it as a divider value
// (D means one event every D+1 clocks). It also flags a stable rate (locked) and a stalled stream (timeout).
module tick_period_meter #(
  parameter int divider_bits = 8,
  parameter int lock_count   = 4,
  parameter int tolerance    = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    tick_in,
  output logic [divider_bits-1:0] period,
  output logic                    period_valid,
  output logic                    locked,
  output logic                    timeout
);

  localparam int streak_bits = $clog2(lock_count + 1);

  localparam logic [1:0] st_idle      = 2'd0;
  localparam logic [1:0] st_measuring = 2'd1;
  localparam logic [1:0] st_locked    = 2'd2;

  localparam logic [divider_bits-1:0] cnt_max  = {divider_bits{1'b1}};
  localparam logic [streak_bits-1:0]  lock_thr = streak_bits'(lock_count);
  localparam logic [divider_bits:0]   tol_w    = (divider_bits + 1)'(tolerance);

  logic [1:0]              state_reg;
  logic [divider_bits-1:0] cnt_reg;
  logic [divider_bits-1:0] period_reg;
  logic [streak_bits-1:0]  streak_reg;
  logic                    valid_reg;
  logic                    locked_reg;
  logic                    timeout_reg;

  logic [divider_bits:0]   cnt_ext;
  logic [divider_bits:0]   prev_ext;
  logic [divider_bits:0]   diff;
  logic [streak_bits-1:0]  streak_next;
  logic                    lock_next;

  // Compare the new interval against the previous one; streak_reg==0 marks the
  // first measurement after leaving IDLE, which has no reference to compare with.
  always_comb begin
    cnt_ext     = {1'b0, cnt_reg};
    prev_ext    = {1'b0, period_reg};
    diff        = (cnt_ext >= prev_ext) ? (cnt_ext - prev_ext) : (prev_ext - cnt_ext);
    streak_next = streak_bits'(1);
    if (streak_reg != '0 && diff <= tol_w) begin
      streak_next = (streak_reg >= lock_thr) ? lock_thr : streak_reg + streak_bits'(1);
    end
    lock_next = (streak_next >= lock_thr);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= st_idle;
      cnt_reg     <= '0;
      period_reg  <= '0;
      streak_reg  <= '0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == st_idle) begin
        cnt_reg <= '0;
        if (tick_in) begin
          state_reg   <= st_measuring;
          timeout_reg <= 1'b0;
          streak_reg  <= '0;
        end
      end else if (tick_in) begin
        cnt_reg    <= '0;
        period_reg <= cnt_reg;
        valid_reg  <= 1'b1;
        streak_reg <= streak_next;
        locked_reg <= lock_next;
        state_reg  <= lock_next ? st_locked : st_measuring;
      end else if (cnt_reg == cnt_max) begin
        // Counter is about to wrap: the stream has stalled, so drop the reference.
        state_reg   <= st_idle;
        cnt_reg     <= '0;
        streak_reg  <= '0;
        locked_reg  <= 1'b0;
        timeout_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + divider_bits'(1);
      end
    end
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign locked       = locked_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: u_dut has tolerance 0, and u_tol has tolerance 1.
// Both instances share the same stimulus.
module tb_tick_period_meter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_in = 1'b0;
  logic [7:0] period, period_t;
  logic       period_valid, locked, timeout;
  logic       pv_t, locked_t, timeout_t;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.divider_bits(8), .lock_count(4), .tolerance(0)) u_dut (
    .clk(clk), .resetn(resetn), .tick_in(tick_in),
    .period(period), .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  tick_period_meter #(.divider_bits(8), .lock_count(4), .tolerance(1)) u_tol (
    .clk(clk), .resetn(resetn), .tick_in(tick_in),
    .period(period_t), .period_valid(pv_t), .locked(locked_t), .timeout(timeout_t)
  );

  // Drive tick_in for one clock; return 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, output int nvalid, output int ntimeout);
    nvalid = 0;
    ntimeout = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0);
      if (period_valid) nvalid++;
      if (timeout) ntimeout++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(1'b1);
    cyc(1'b1);
    checks++; if (period !== 8'd0) $display("FAIL reset_period: got %0d want 0", period); else passed++;
    checks++; if (period_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", period_valid); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
    tick_in = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_divider5();
    int nv, nt;
    do_reset();
    cyc(1'b1);
    checks++; if (period_valid !== 1'b0) $display("FAIL d5_first_event_valid: got %b want 0", period_valid); else passed++;
    for (int k = 2; k <= 6; k++) begin
      idle(5, nv, nt);
      checks++; if (nv !== 0) $display("FAIL d5_idle_valid ev%0d: got %0d pulses want 0", k, nv); else passed++;
      cyc(1'b1);
      checks++; if (period_valid !== 1'b1) $display("FAIL d5_valid ev%0d: got %b want 1", k, period_valid); else passed++;
      checks++; if (period !== 8'd5) $display("FAIL d5_period ev%0d: got %0d want 5", k, period); else passed++;
      checks++; if (locked !== (k >= 5)) $display("FAIL d5_locked ev%0d: got %b want %b", k, locked, (k >= 5)); else passed++;
      $display("divider5 event %0d: period=%0d valid=%b locked=%b", k, period, period_valid, locked);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1);
      checks++; if (period_valid !== (i >= 2)) $display("FAIL b2b_valid cyc%0d: got %b want %b", i, period_valid, (i >= 2)); else passed++;
      checks++; if (period !== 8'd0) $display("FAIL b2b_period cyc%0d: got %0d want 0", i, period); else passed++;
      checks++; if (locked !== (i >= 5)) $display("FAIL b2b_locked cyc%0d: got %b want %b", i, locked, (i >= 5)); else passed++;
      $display("back_to_back cycle %0d: period=%0d valid=%b locked=%b", i, period, period_valid, locked);
    end
    tick_in = 1'b0;
  endtask

  task automatic test_rate_change();
    int nv, nt;
    do_reset();
    cyc(1'b1);
    repeat (4) begin idle(5, nv, nt); cyc(1'b1); end
    checks++; if (locked !== 1'b1) $display("FAIL rc_initial_lock: got %b want 1", locked); else passed++;
    idle(8, nv, nt);
    cyc(1'b1);
    checks++; if (period !== 8'd8) $display("FAIL rc_period8: got %0d want 8", period); else passed++;
    checks++; if (period_valid !== 1'b1) $display("FAIL rc_valid8: got %b want 1", period_valid); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL rc_unlock: got %b want 0", locked); else passed++;
    $display("rate_change slow interval: period=%0d locked=%b", period, locked);
    for (int j = 1; j <= 4; j++) begin
      idle(5, nv, nt);
      cyc(1'b1);
      checks++; if (period !== 8'd5) $display("FAIL rc_period5 m%0d: got %0d want 5", j, period); else passed++;
      checks++; if (locked !== (j == 4)) $display("FAIL rc_relock m%0d: got %b want %b", j, locked, (j == 4)); else passed++;
      $display("rate_change return %0d: period=%0d locked=%b", j, period, locked);
    end
  endtask

  task automatic test_timeout();
    int nv, nt;
    do_reset();
    cyc(1'b1);
    repeat (4) begin idle(5, nv, nt); cyc(1'b1); end
    checks++; if (locked !== 1'b1) $display("FAIL to_prelock: got %b want 1", locked); else passed++;
    idle(255, nv, nt);
    checks++; if (nt !== 0) $display("FAIL to_early: got %0d timeout cycles want 0", nt); else passed++;
    cyc(1'b0);
    checks++; if (timeout !== 1'b1) $display("FAIL to_assert: got %b want 1", timeout); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL to_locked: got %b want 0", locked); else passed++;
    checks++; if (period !== 8'd5) $display("FAIL to_period_kept: got %0d want 5", period); else passed++;
    checks++; if (period_valid !== 1'b0) $display("FAIL to_valid: got %b want 0", period_valid); else passed++;
    $display("timeout asserted: timeout=%b locked=%b period=%0d", timeout, locked, period);
    idle(10, nv, nt);
    checks++; if (nt !== 10) $display("FAIL to_hold: got %0d timeout cycles want 10", nt); else passed++;
    cyc(1'b1);
    checks++; if (timeout !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout); else passed++;
    checks++; if (period_valid !== 1'b0) $display("FAIL to_restart_valid: got %b want 0", period_valid); else passed++;
    idle(6, nv, nt);
    cyc(1'b1);
    checks++; if (period !== 8'd6) $display("FAIL to_remeasure_period: got %0d want 6", period); else passed++;
    checks++; if (period_valid !== 1'b1) $display("FAIL to_remeasure_valid: got %b want 1", period_valid); else passed++;
    $display("timeout recovery: period=%0d valid=%b", period, period_valid);
  endtask

  task automatic test_max_interval();
    int nv, nt;
    do_reset();
    cyc(1'b1);
    idle(255, nv, nt);
    checks++; if (nt !== 0) $display("FAIL max_early_timeout: got %0d want 0", nt); else passed++;
    cyc(1'b1);
    checks++; if (period !== 8'd255) $display("FAIL max_period: got %0d want 255", period); else passed++;
    checks++; if (period_valid !== 1'b1) $display("FAIL max_valid: got %b want 1", period_valid); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL max_timeout: got %b want 0", timeout); else passed++;
    cyc(1'b0);
    checks++; if (timeout !== 1'b0) $display("FAIL max_timeout_after: got %b want 0", timeout); else passed++;
    $display("max interval: period=%0d timeout=%b", period, timeout);
  endtask

  task automatic test_tolerance();
    int nv, nt;
    int gaps [4] = '{10, 11, 10, 11};
    do_reset();
    cyc(1'b1);
    for (int j = 0; j < 4; j++) begin
      idle(gaps[j], nv, nt);
      cyc(1'b1);
      checks++; if (period_t !== 8'(gaps[j])) $display("FAIL tol_period m%0d: got %0d want %0d", j, period_t, gaps[j]); else passed++;
      checks++; if (locked_t !== (j == 3)) $display("FAIL tol_locked m%0d: got %b want %b", j, locked_t, (j == 3)); else passed++;
      checks++; if (locked !== 1'b0) $display("FAIL tol0_locked m%0d: got %b want 0", j, locked); else passed++;
      $display("tolerance meas %0d: period=%0d locked_tol1=%b locked_tol0=%b", j, period_t, locked_t, locked);
    end
    idle(3, nv, nt);
    resetn = 1'b0;
    cyc(1'b0);
    checks++; if (period_t !== 8'd0) $display("FAIL midrst_period: got %0d want 0", period_t); else passed++;
    checks++; if (pv_t !== 1'b0) $display("FAIL midrst_valid: got %b want 0", pv_t); else passed++;
    checks++; if (locked_t !== 1'b0) $display("FAIL midrst_locked: got %b want 0", locked_t); else passed++;
    checks++; if (timeout_t !== 1'b0) $display("FAIL midrst_timeout: got %b want 0", timeout_t); else passed++;
    resetn = 1'b1;
    cyc(1'b1);
    checks++; if (pv_t !== 1'b0) $display("FAIL postrst_first_valid: got %b want 0", pv_t); else passed++;
    idle(10, nv, nt);
    cyc(1'b1);
    checks++; if (period_t !== 8'd10) $display("FAIL postrst_period: got %0d want 10", period_t); else passed++;
    checks++; if (pv_t !== 1'b1) $display("FAIL postrst_valid: got %b want 1", pv_t); else passed++;
    checks++; if (locked_t !== 1'b0) $display("FAIL postrst_locked: got %b want 0", locked_t); else passed++;
    $display("post reset measurement: period=%0d valid=%b locked=%b", period_t, pv_t, locked_t);
  endtask

  initial begin
    test_reset();
    test_divider5();
    test_back_to_back();
    test_rate_change();
    test_timeout();
    test_max_interval();
    test_tolerance();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures the cycle interval between events on a tick stream and reports it as a divider value.
- The value uses the same encoding a free-running divider uses: D means one tick every D+1 clocks.
- Used to recover the rate of step/tick streams from other blocks or external sources, and to flag when a stream has a stable rate ("locked") or has stopped ("timeout").
- Fully synchronous to clk; tick_in must already be synchronous to clk.

Parameters:
- divider_bits, 8: width of the measured period and the internal interval counter.
- lock_count, 4: number of consecutive in-tolerance measurements required to assert locked (minimum 1).
- tolerance, 0: maximum absolute difference (in clocks) between consecutive measurements still counted as "same rate".

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous, active-low reset.
- tick_in  input  1  event input; every clk cycle where tick_in=1 is one event (no edge detection).
- period  output  divider_bits  last valid measured divider value.
- period_valid  output  1  single-cycle pulse when period is updated.
- locked  output  1  stream rate stable.
- timeout  output  1  no event within 2^divider_bits clocks of the previous event.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, cnt=0, streak=0, period=0, period_valid=0, locked=0, timeout=0. Applies mid-measurement; the partial interval is discarded.
- States: IDLE (no reference event), MEASURING, LOCKED.
- cnt behaviour:
  - cnt is divider_bits wide.
  - On an event cycle: cnt<=0.
  - Otherwise, in MEASURING/LOCKED: cnt<=cnt+1.
  - In IDLE, cnt holds 0.
  - Consequence: at an event arriving D+1 clocks after the previous event, cnt==D.
- IDLE + event: go to MEASURING, clear timeout, streak<=0. No period_valid.
- MEASURING/LOCKED + event:
  - period<=cnt; period_valid<=1 on the next cycle (1-cycle latency from the event cycle).
  - diff = |cnt - period_prev|, computed in divider_bits+1 bits with no wrap.
  - On the first measurement after IDLE, streak<=1.
  - Else, if diff<=tolerance, streak<=min(streak+1, lock_count).
  - Else streak<=1.
  - locked<=(streak_next>=lock_count), updated in the same cycle as period_valid. State follows locked (LOCKED or MEASURING).
- MEASURING/LOCKED, no event, cnt==2^divider_bits-1:
  - Next state IDLE; timeout<=1, locked<=0, streak<=0, cnt<=0.
  - period keeps its last value.
  - An event exactly at cnt==2^divider_bits-1 is a valid measurement (max divider), not a timeout.
- timeout stays high in IDLE until the next event. It clears on the cycle after that event.
- period_valid is 0 in every cycle not following a measuring event.
- Back-to-back events (tick_in held high) measure 0 every cycle: period=0, period_valid continuously high.
- lock_count=1: locked asserts with the first measurement.

Test Plan:
- Reset, then tick_in from a divider=5 source (1 every 6 clocks) → first event gives no valid. period=5 with period_valid pulses every 6 clocks starting 1 cycle after the 2nd event. locked=1 with the 4th valid measurement (5th event).
- tick_in held high from reset release → period_valid high from the 2nd cycle onward, period=0, locked after 4 measurements.
- Locked at D=5, then one interval of 9 clocks → period=8, locked drops at that pulse. Return to D=5 → locked again after 4 consecutive D=5 measurements (the 8→5 mismatch restarts streak at 1).
- divider_bits=8, event at cycle t then none → timeout=1 and locked=0 from cycle t+257, period unchanged. Next event clears timeout with no period_valid. The following event measures correctly.
- Interval of exactly 256 clocks (cnt=255 at event) → period=255 valid, no timeout.
- tolerance=1, intervals alternating D=10/11 → locked asserts. resetn pulsed low mid-interval → all outputs 0 the next cycle and the first post-reset event produces no period_valid.
